// File: rtl/vending_controller.sv
// Vending controller for four products: accumulates coin credit, dispenses
// on an affordable selection and returns change on dispense, cancel or
// inactivity timeout. All pulse outputs are registered.
module vending_controller #(
  parameter int unsigned COIN_W     = 6,
  parameter int unsigned CREDIT_W   = 8,
  parameter int unsigned CREDIT_MAX = 255,
  parameter int unsigned PRICE0     = 15,
  parameter int unsigned PRICE1     = 30,
  parameter int unsigned PRICE2     = 45,
  parameter int unsigned PRICE3     = 60,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned TO_W       = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [COIN_W-1:0]   coin_value,
  input  logic                sel_valid,
  input  logic [1:0]          sel_id,
  input  logic                cancel,
  output logic [CREDIT_W-1:0] credit,
  output logic [3:0]          afford,
  output logic                dispense_valid,
  output logic [1:0]          dispense_id,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amount,
  output logic                coin_reject,
  output logic                sel_reject,
  output logic                busy
);

  // One extra bit so credit + coin can never wrap before the limit check.
  localparam int unsigned SumW = CREDIT_W + 1;

  localparam logic [SumW-1:0]     CreditMaxW  = SumW'(CREDIT_MAX);
  localparam logic [CREDIT_W-1:0] Price0      = CREDIT_W'(PRICE0);
  localparam logic [CREDIT_W-1:0] Price1      = CREDIT_W'(PRICE1);
  localparam logic [CREDIT_W-1:0] Price2      = CREDIT_W'(PRICE2);
  localparam logic [CREDIT_W-1:0] Price3      = CREDIT_W'(PRICE3);
  localparam logic [TO_W-1:0]     TimeoutLast = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StCredit,
    StDispense,
    StChange
  } state_e;

  state_e              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [TO_W-1:0]     to_q, to_d;
  logic                dispense_valid_q, dispense_valid_d;
  logic [1:0]          dispense_id_q, dispense_id_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amount_q, change_amount_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_reject_q, sel_reject_d;

  logic [SumW-1:0]     coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] price_sel;
  logic [TO_W-1:0]     to_inc;
  logic                sel_ev;
  logic                coin_ev;
  logic                coin_lost;

  // Event arbitration, coin acceptance and price lookup.
  always_comb begin
    sel_ev    = sel_valid & ~cancel;
    coin_ev   = coin_valid & ~cancel & ~sel_valid;
    coin_lost = coin_valid & (cancel | sel_valid);
    coin_sum  = {1'b0, credit_q} + SumW'(coin_value);
    coin_ok   = (coin_value != '0) && (coin_sum <= CreditMaxW);
    to_inc    = to_q + TO_W'(1);
    case (sel_id)
      2'd0:    price_sel = Price0;
      2'd1:    price_sel = Price1;
      2'd2:    price_sel = Price2;
      default: price_sel = Price3;
    endcase
  end

  // Next-state and registered-pulse logic.
  always_comb begin
    state_d          = state_q;
    credit_d         = credit_q;
    to_d             = to_q;
    dispense_valid_d = 1'b0;
    dispense_id_d    = 2'd0;
    change_valid_d   = 1'b0;
    change_amount_d  = '0;
    coin_reject_d    = coin_lost;
    sel_reject_d     = 1'b0;

    case (state_q)
      StIdle: begin
        // Cancel with no credit has nothing to return.
        if (sel_ev) begin
          sel_reject_d = 1'b1;
        end else if (coin_ev) begin
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            to_d     = '0;
            state_d  = StCredit;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end

      StCredit: begin
        if (cancel) begin
          state_d = StChange;
        end else if (sel_ev) begin
          if (credit_q >= price_sel) begin
            credit_d         = credit_q - price_sel;
            dispense_valid_d = 1'b1;
            dispense_id_d    = sel_id;
            state_d          = StDispense;
          end else begin
            sel_reject_d = 1'b1;
            to_d         = '0;
          end
        end else if (coin_ev) begin
          // Any coin counts as customer activity, accepted or not.
          to_d = '0;
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
          end else begin
            coin_reject_d = 1'b1;
          end
        end else begin
          to_d = to_inc;
          if (to_inc == TimeoutLast) begin
            state_d = StChange;
          end
        end
      end

      StDispense: begin
        if (coin_valid) coin_reject_d = 1'b1;
        if (sel_ev)     sel_reject_d  = 1'b1;
        state_d = (credit_q != '0) ? StChange : StIdle;
      end

      StChange: begin
        if (coin_valid) coin_reject_d = 1'b1;
        if (sel_ev)     sel_reject_d  = 1'b1;
        change_valid_d  = 1'b1;
        change_amount_d = credit_q;
        credit_d        = '0;
        state_d         = StIdle;
      end

      default: begin
        state_d  = StIdle;
        credit_d = '0;
      end
    endcase
  end

  // State, credit, timeout counter and output pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      credit_q         <= '0;
      to_q             <= '0;
      dispense_valid_q <= 1'b0;
      dispense_id_q    <= 2'd0;
      change_valid_q   <= 1'b0;
      change_amount_q  <= '0;
      coin_reject_q    <= 1'b0;
      sel_reject_q     <= 1'b0;
    end else begin
      state_q          <= state_d;
      credit_q         <= credit_d;
      to_q             <= to_d;
      dispense_valid_q <= dispense_valid_d;
      dispense_id_q    <= dispense_id_d;
      change_valid_q   <= change_valid_d;
      change_amount_q  <= change_amount_d;
      coin_reject_q    <= coin_reject_d;
      sel_reject_q     <= sel_reject_d;
    end
  end

  // Affordability and busy decode straight from registered state.
  always_comb begin
    afford = 4'b0000;
    if (state_q == StCredit) begin
      afford[0] = (credit_q >= Price0);
      afford[1] = (credit_q >= Price1);
      afford[2] = (credit_q >= Price2);
      afford[3] = (credit_q >= Price3);
    end
    busy = (state_q == StDispense) || (state_q == StChange);
  end

  assign credit         = credit_q;
  assign dispense_valid = dispense_valid_q;
  assign dispense_id    = dispense_id_q;
  assign change_valid   = change_valid_q;
  assign change_amount  = change_amount_q;
  assign coin_reject    = coin_reject_q;
  assign sel_reject     = sel_reject_q;

endmodule
